// File: rtl/apb_io_regs.sv
// apb_io_regs: APB slave with a GPIO output register, synchronized input
// port with masked rising-edge event flags, and a down-counting timer.
// Interrupt is the registered OR of pending events and the gated timer flag.
module apb_io_regs #(
  parameter int WAIT_STATES = 1
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [4:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  input  logic [7:0] INREG,
  output logic [7:0] OUTREG,
  output logic       IRQ
);

  localparam logic       S_IDLE   = 1'b0;
  localparam logic       S_ACCESS = 1'b1;
  localparam logic [1:0] WS       = 2'(WAIT_STATES);

  logic       state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;

  logic [7:0] out_q, out_d;
  logic [7:0] sync1_q, in_q, prev_q;
  logic [7:0] emask_q, emask_d;
  logic [7:0] eflag_q, eflag_d;
  logic       en_q, en_d, auto_q, auto_d, tie_q, tie_d;
  logic [7:0] treload_q, treload_d;
  logic [7:0] tcount_q, tcount_d;
  logic       texp_q, texp_d;
  logic       irq_q;
  logic       wr_en, expire;
  logic [7:0] rdata;

  assign PREADY = (state_q == S_ACCESS) && PSEL && PENABLE && (wcnt_q == WS);
  assign wr_en  = PREADY && PWRITE;
  assign PRDATA = PREADY ? rdata : 8'h00;
  assign OUTREG = out_q;
  assign IRQ    = irq_q;

  // APB handshake: count wait cycles in ACCESS, leave on completion or PSEL drop
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = S_ACCESS;
          wcnt_d  = 2'd0;
        end
      end
      default: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          wcnt_d  = 2'd0;
        end else if (!PENABLE) begin
          wcnt_d = 2'd0;  // a fresh setup phase restarts the wait count
        end else if (wcnt_q == WS) begin
          state_d = S_IDLE;
          wcnt_d  = 2'd0;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
    endcase
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rdata = 8'h00;
    case (PADDR)
      5'h00: rdata = out_q;
      5'h01: rdata = in_q;
      5'h02: rdata = emask_q;
      5'h03: rdata = eflag_q;
      5'h04: rdata = {5'b0, tie_q, auto_q, en_q};
      5'h05: rdata = treload_q;
      5'h06: rdata = tcount_q;
      5'h07: rdata = {7'b0, texp_q};
      default: rdata = 8'h00;
    endcase
  end

  // Register writes, event flags and timer; hardware set beats software clear
  always_comb begin
    out_d     = out_q;
    emask_d   = emask_q;
    treload_d = treload_q;
    auto_d    = auto_q;
    tie_d     = tie_q;
    en_d      = en_q;
    tcount_d  = tcount_q;
    expire    = 1'b0;

    if (en_q) begin
      if (tcount_q != 8'h00) begin
        tcount_d = tcount_q - 8'h01;
      end else begin
        expire = 1'b1;
        if (auto_q) tcount_d = treload_q;
        else        en_d     = 1'b0;
      end
    end

    if (wr_en) begin
      case (PADDR)
        5'h00: out_d     = PWDATA;
        5'h02: emask_d   = PWDATA;
        5'h05: treload_d = PWDATA;
        5'h04: begin
          en_d   = PWDATA[0];
          auto_d = PWDATA[1];
          tie_d  = PWDATA[2];
          if (PWDATA[0]) tcount_d = treload_q;
        end
        default: ;
      endcase
    end

    eflag_d = (eflag_q & ~((wr_en && PADDR == 5'h03) ? PWDATA : 8'h00))
            | (in_q & ~prev_q & emask_q);
    texp_d  = (texp_q & ~(wr_en && PADDR == 5'h07 && PWDATA[0])) | expire;
  end

  // State registers, input synchronizer and registered interrupt
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 2'd0;
      out_q     <= 8'h00;
      sync1_q   <= 8'h00;
      in_q      <= 8'h00;
      prev_q    <= 8'h00;
      emask_q   <= 8'h00;
      eflag_q   <= 8'h00;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      tie_q     <= 1'b0;
      treload_q <= 8'h00;
      tcount_q  <= 8'h00;
      texp_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      out_q     <= out_d;
      sync1_q   <= INREG;
      in_q      <= sync1_q;
      prev_q    <= in_q;
      emask_q   <= emask_d;
      eflag_q   <= eflag_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      tie_q     <= tie_d;
      treload_q <= treload_d;
      tcount_q  <= tcount_d;
      texp_q    <= texp_d;
      irq_q     <= (|eflag_q) | (texp_q & tie_q);
    end
  end

endmodule

// File: tb/tb_apb_io_regs.sv
// Scoreboard bench for apb_io_regs: the driver queues the expected read data
// per transfer, a negedge monitor pops and compares whenever PREADY is high.
module tb_apb_io_regs;
  localparam int WS = 1;

  logic       PCLK, PRESETn, PSEL, PENABLE, PWRITE, PREADY, IRQ;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA, INREG, OUTREG;

  typedef struct {
    logic       chk;
    logic [7:0] data;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  apb_io_regs #(.WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .INREG(INREG), .OUTREG(OUTREG), .IRQ(IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  // One APB transfer; starts just after a rising edge, returns just after the
  // commit edge so consecutive calls issue back-to-back setup phases.
  task automatic xfer(input logic wr, input logic [4:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input string nm);
    exp_t e;
    int   k;
    e.chk = !wr; e.data = exp_rd; e.nm = nm;
    sb.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1; #1;
    k = 0;
    while (!PREADY && k < 16) begin
      @(posedge PCLK); #2;
      k++;
    end
    check({nm, "_waits"}, 8'(k), 8'(WS));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d, input string nm);
    xfer(1'b1, a, d, 8'h00, nm);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string nm);
    xfer(1'b0, a, 8'h00, exp, nm);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Monitor: compare read data on completion, PRDATA must idle at zero
  always @(negedge PCLK) begin
    if (PREADY) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pready: got PREADY=1 expected no transfer pending");
      end else begin
        me = sb.pop_front();
        if (me.chk) check(me.nm, PRDATA, me.data);
      end
    end else begin
      check("prdata_idle", PRDATA, 8'h00);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 5'h00; PWDATA = 8'h00; INREG = 8'h00;
    #1;
    check("rst_outreg", OUTREG, 8'h00);
    check("rst_irq", 8'(IRQ), 8'h00);
    check("rst_pready", 8'(PREADY), 8'h00);
    check("rst_prdata", PRDATA, 8'h00);
    cyc(2);
    PRESETn = 1'b1;
    cyc(1);

    // basic write/read, unmapped space
    wr(5'h00, 8'h5A, "wr_out");
    check("outreg_5a", OUTREG, 8'h5A);
    rd(5'h00, 8'h5A, "rd_out");
    rd(5'h15, 8'h00, "rd_unmapped");
    wr(5'h1F, 8'hFF, "wr_unmapped");
    rd(5'h1F, 8'h00, "rd_unmapped_1f");

    // masked rising edge -> EFLAG, IRQ one cycle later
    wr(5'h02, 8'h01, "wr_emask");
    rd(5'h02, 8'h01, "rd_emask");
    INREG = 8'h01;
    cyc(3);
    check("irq_pre", 8'(IRQ), 8'h00);
    cyc(1);
    check("irq_event", 8'(IRQ), 8'h01);
    rd(5'h01, 8'h01, "rd_in");
    rd(5'h03, 8'h01, "rd_eflag");
    wr(5'h03, 8'h01, "w1c_eflag");
    cyc(1);
    check("irq_cleared", 8'(IRQ), 8'h00);
    rd(5'h03, 8'h00, "rd_eflag_clr");

    // edge arrives on the same edge as the W1C commit
    INREG = 8'h00; cyc(4);
    INREG = 8'h01; cyc(4);
    rd(5'h03, 8'h01, "eflag_before");
    INREG = 8'h00; cyc(4);
    INREG = 8'h01;
    wr(5'h03, 8'h01, "w1c_coincide");
    rd(5'h03, 8'h01, "eflag_set_wins");
    wr(5'h03, 8'h01, "w1c_clean");
    rd(5'h03, 8'h00, "eflag_clean");
    cyc(2);
    check("irq_idle", 8'(IRQ), 8'h00);

    // one-shot timer, reload 3
    wr(5'h05, 8'h03, "wr_treload");
    wr(5'h04, 8'h05, "wr_tctrl_oneshot");
    rd(5'h06, 8'h01, "tcount_1");
    rd(5'h06, 8'h00, "tcount_0");
    rd(5'h04, 8'h04, "tctrl_en_clr");
    rd(5'h07, 8'h01, "texp_set");
    check("irq_texp", 8'(IRQ), 8'h01);
    wr(5'h07, 8'h01, "w1c_texp");
    rd(5'h07, 8'h00, "texp_clr");
    check("irq_texp_clr", 8'(IRQ), 8'h00);

    // auto-reload, expiry every 4 cycles
    wr(5'h04, 8'h07, "wr_tctrl_auto");
    rd(5'h07, 8'h00, "auto_texp0");
    wr(5'h07, 8'h01, "auto_w1c_a");
    rd(5'h07, 8'h01, "auto_texp_reset");
    wr(5'h07, 8'h01, "auto_w1c_vs_expire");
    rd(5'h07, 8'h01, "texp_set_wins");
    rd(5'h06, 8'h02, "auto_tcount");
    wr(5'h04, 8'h00, "stop_auto");
    wr(5'h07, 8'h01, "w1c_after_stop");
    rd(5'h07, 8'h00, "texp_stopped");

    // reload of zero with auto: expires every cycle
    wr(5'h05, 8'h00, "wr_treload0");
    wr(5'h04, 8'h03, "wr_tctrl_r0");
    wr(5'h07, 8'h01, "w1c_r0");
    rd(5'h07, 8'h01, "r0_texp");
    rd(5'h06, 8'h00, "r0_tcount");
    wr(5'h04, 8'h00, "stop_r0");
    wr(5'h07, 8'h01, "w1c_r0_stop");
    rd(5'h07, 8'h00, "r0_texp_clr");

    // read-only registers ignore writes
    wr(5'h05, 8'h20, "wr_treload20");
    wr(5'h04, 8'h01, "start_20");
    wr(5'h04, 8'h00, "stop_20");
    wr(5'h06, 8'hFF, "wr_tcount_ro");
    rd(5'h06, 8'h1D, "tcount_ro");
    wr(5'h01, 8'hFF, "wr_in_ro");
    rd(5'h01, 8'h01, "in_ro");

    // PSEL dropped while waiting: no commit
    wr(5'h00, 8'hA5, "wr_out_a5");
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h00; PWDATA = 8'h3C;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    cyc(2);
    check("out_after_abort", OUTREG, 8'hA5);
    rd(5'h00, 8'hA5, "rd_after_abort");

    // reset pulse mid-write
    INREG = 8'h00; cyc(4);
    INREG = 8'h01; cyc(5);
    check("irq_before_rst", 8'(IRQ), 8'h01);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h00; PWDATA = 8'h77;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    check("midrst_outreg", OUTREG, 8'h00);
    check("midrst_irq", 8'(IRQ), 8'h00);
    check("midrst_pready", 8'(PREADY), 8'h00);
    check("midrst_prdata", PRDATA, 8'h00);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    cyc(1);
    PRESETn = 1'b1;
    cyc(1);
    rd(5'h00, 8'h00, "out_after_rst");
    rd(5'h02, 8'h00, "emask_after_rst");
    wr(5'h00, 8'h3C, "wr_after_rst");
    check("outreg_3c", OUTREG, 8'h3C);
    rd(5'h00, 8'h3C, "rd_after_rst");

    cyc(2);
    check("sb_empty", 8'(sb.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
